// File: rtl/inst_cache_pkg.sv
// Shared widths, enable levels and state encodings for the instruction cache.
// Imported by the cache top and its storage sub-module.
package inst_cache_pkg;

    localparam int RegBus      = 32;
    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic RstEnable  = 1'b1;
    localparam logic ChipEnable = 1'b1;

    localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

    typedef enum logic {
        IcIdle = 1'b0,
        IcReq  = 1'b1
    } ic_state_t;

    // Byte address -> word-aligned address (low two bits forced to zero).
    function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays of the direct-mapped instruction cache:
// asynchronous lookup port, synchronous fill port, synchronous clear-all of valid bits.
module icache_store
    import inst_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               rd_hit,
    output logic [InstBus-1:0] rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [InstBus-1:0] wr_data
);

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [InstBus-1:0] data_mem [LINES];

    assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data = data_mem[rd_idx];

    // Clear beats a simultaneous fill: the line is written but left invalid.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with same-cycle hits and
// a req/ack refill from external memory on a miss.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_ce_i,
    input  logic [InstAddrBus-1:0] cpu_addr_i,
    output logic [InstBus-1:0]     cpu_data_o,
    output logic                   stallreq_o,
    input  logic                   inv_i,
    output logic                   mem_req_o,
    output logic [InstAddrBus-1:0] mem_addr_o,
    input  logic [RegBus-1:0]      mem_data_i,
    input  logic                   mem_ack_i,
    output logic [CNT_W-1:0]       miss_cnt_o
);

    localparam int TAG_W = 30 - IDX_W;

    ic_state_t          state;
    logic               in_rst;
    logic               fetch;
    logic               hit;
    logic [InstBus-1:0] hit_data;
    logic               fill;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_rst = (rst == RstEnable);
    assign fetch  = (cpu_ce_i == ChipEnable);
    assign fill   = !in_rst && (state == IcReq) && mem_ack_i;

    icache_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clk     (clk),
        .clr     (in_rst || inv_i),
        .rd_idx  (cpu_addr_i[IDX_W+1:2]),
        .rd_tag  (cpu_addr_i[31:IDX_W+2]),
        .rd_hit  (hit),
        .rd_data (hit_data),
        .wr_en   (fill),
        .wr_idx  (mem_addr_o[IDX_W+1:2]),
        .wr_tag  (mem_addr_o[31:IDX_W+2]),
        .wr_data (mem_data_i)
    );

    // Lookup outputs depend only on state, the core address and the arrays.
    always_comb begin
        cpu_data_o = ZeroWord;
        stallreq_o = 1'b0;
        if (!in_rst) begin
            if (state == IcReq) begin
                stallreq_o = 1'b1;
            end else if (fetch) begin
                if (hit) begin
                    cpu_data_o = hit_data;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_rst) begin
            state      <= IcIdle;
            mem_req_o  <= 1'b0;
            mem_addr_o <= ZeroWord;
            miss_cnt_o <= '0;
        end else begin
            case (state)
                IcIdle: begin
                    if (fetch && !hit) begin
                        mem_addr_o <= align_word(cpu_addr_i);
                        mem_req_o  <= 1'b1;
                        miss_cnt_o <= sat_inc(miss_cnt_o);
                        state      <= IcReq;
                    end
                end
                IcReq: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IcIdle;
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                    state     <= IcIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cycle-by-cycle vector table for the basic
// miss/hit/conflict flow, then hand-written sequences for inv, reset and ce corner cases.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        inv_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;
    logic [15:0] miss_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    inst_cache #(.LINES(16), .IDX_W(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .inv_i      (inv_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i),
        .miss_cnt_o (miss_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ce;
        logic [31:0] addr;
        logic        ack;
        logic [31:0] md;
        logic        inv;
        logic        r;
        logic [31:0] e_data;
        logic        e_stall;
        logic        e_req;
        logic [31:0] e_maddr;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input string name, input logic ce, input logic [31:0] addr,
                                input logic ack, input logic [31:0] md, input logic inv,
                                input logic r, input logic [31:0] e_data, input logic e_stall,
                                input logic e_req, input logic [31:0] e_maddr,
                                input logic [15:0] e_cnt);
        vec_t v;
        v.name = name; v.ce = ce; v.addr = addr; v.ack = ack; v.md = md; v.inv = inv; v.r = r;
        v.e_data = e_data; v.e_stall = e_stall; v.e_req = e_req; v.e_maddr = e_maddr;
        v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs are applied just after a rising edge, outputs sampled on the falling edge.
    task automatic step(input vec_t v);
        cpu_ce_i   = v.ce;
        cpu_addr_i = v.addr;
        mem_ack_i  = v.ack;
        mem_data_i = v.md;
        inv_i      = v.inv;
        rst        = v.r;
        @(negedge clk);
        chk({v.name, ".data"},  cpu_data_o,          v.e_data);
        chk({v.name, ".stall"}, {31'd0, stallreq_o}, {31'd0, v.e_stall});
        chk({v.name, ".req"},   {31'd0, mem_req_o},  {31'd0, v.e_req});
        chk({v.name, ".maddr"}, mem_addr_o,          v.e_maddr);
        chk({v.name, ".cnt"},   {16'd0, miss_cnt_o}, {16'd0, v.e_cnt});
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[12];

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cpu_ce_i = 1'b1; cpu_addr_i = 32'h4; inv_i = 1'b0;
        mem_ack_i = 1'b0; mem_data_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        step(mk("rst", 1, 32'h4, 0, 0, 0, 1,  32'h0, 0, 0, 32'h0, 16'd0));

        // Tests 1-3: first miss with ack in 3rd REQ cycle, hit, conflict, re-miss.
        tbl[0]  = mk("t1.miss",  1, 32'h04,  0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h00, 16'd0);
        tbl[1]  = mk("t1.req1",  1, 32'h04,  0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h04, 16'd1);
        tbl[2]  = mk("t1.req2",  1, 32'h04,  0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h04, 16'd1);
        tbl[3]  = mk("t1.ack",   1, 32'h04,  1, 32'h3401_0020, 0, 0, 32'h0,         1, 1, 32'h04, 16'd1);
        tbl[4]  = mk("t1.hit",   1, 32'h04,  0, 32'h0,         0, 0, 32'h3401_0020, 0, 0, 32'h04, 16'd1);
        tbl[5]  = mk("t2.hit",   1, 32'h04,  0, 32'h0,         0, 0, 32'h3401_0020, 0, 0, 32'h04, 16'd1);
        tbl[6]  = mk("t3.miss",  1, 32'h44,  1, 32'hBAD0_BAD0, 0, 0, 32'h0,         1, 0, 32'h04, 16'd1);
        tbl[7]  = mk("t3.ack",   1, 32'h100, 1, 32'h3402_0011, 0, 0, 32'h0,         1, 1, 32'h44, 16'd2);
        tbl[8]  = mk("t3.hit",   1, 32'h44,  0, 32'h0,         0, 0, 32'h3402_0011, 0, 0, 32'h44, 16'd2);
        tbl[9]  = mk("t3.remiss",1, 32'h04,  0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h44, 16'd2);
        tbl[10] = mk("t3.ack2",  1, 32'h04,  1, 32'h3401_0020, 0, 0, 32'h0,         1, 1, 32'h04, 16'd3);
        tbl[11] = mk("t3.hit2",  1, 32'h04,  0, 32'h0,         0, 0, 32'h3401_0020, 0, 0, 32'h04, 16'd3);
        for (int i = 0; i < 12; i++) step(tbl[i]);

        // Test 4a: invalidate in IDLE, then the line must refill.
        step(mk("t4.inv",    0, 32'h04, 0, 32'h0,         1, 0, 32'h0,         0, 0, 32'h04, 16'd3));
        step(mk("t4.miss",   1, 32'h04, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h04, 16'd3));
        step(mk("t4.ack",    1, 32'h04, 1, 32'h3401_0020, 0, 0, 32'h0,         1, 1, 32'h04, 16'd4));
        step(mk("t4.hit",    1, 32'h04, 0, 32'h0,         0, 0, 32'h3401_0020, 0, 0, 32'h04, 16'd4));
        // Test 4b: inv on the ack edge leaves the fresh line invalid.
        step(mk("t4b.miss",  1, 32'h44, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h04, 16'd4));
        step(mk("t4b.ackinv",1, 32'h44, 1, 32'h3402_0011, 1, 0, 32'h0,         1, 1, 32'h44, 16'd5));
        step(mk("t4b.remiss",1, 32'h44, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h44, 16'd5));
        step(mk("t4b.ack",   1, 32'h44, 1, 32'h3402_0011, 0, 0, 32'h0,         1, 1, 32'h44, 16'd6));
        step(mk("t4b.hit",   1, 32'h44, 0, 32'h0,         0, 0, 32'h3402_0011, 0, 0, 32'h44, 16'd6));
        // inv during REQ without ack: pending fill still installs valid.
        step(mk("t4c.miss",  1, 32'h08, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h44, 16'd6));
        step(mk("t4c.inv",   1, 32'h08, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h08, 16'd7));
        step(mk("t4c.ack",   1, 32'h08, 1, 32'hAABB_0008, 0, 0, 32'h0,         1, 1, 32'h08, 16'd7));
        step(mk("t4c.hit",   1, 32'h08, 0, 32'h0,         0, 0, 32'hAABB_0008, 0, 0, 32'h08, 16'd7));

        // Test 5: reset in the 2nd REQ cycle abandons the refill and clears lines.
        step(mk("t5.miss",   1, 32'h0C, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h08, 16'd7));
        step(mk("t5.req1",   1, 32'h0C, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h0C, 16'd8));
        step(mk("t5.rst",    1, 32'h0C, 0, 32'h0,         0, 1, 32'h0,         0, 1, 32'h0C, 16'd8));
        step(mk("t5.after",  0, 32'h0C, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h00, 16'd0));
        step(mk("t5.remiss", 1, 32'h08, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h00, 16'd0));
        step(mk("t5.ack",    1, 32'h08, 1, 32'hAABB_0008, 0, 0, 32'h0,         1, 1, 32'h08, 16'd1));
        step(mk("t5.hit",    1, 32'h08, 0, 32'h0,         0, 0, 32'hAABB_0008, 0, 0, 32'h08, 16'd1));

        // Test 6: stray ack in IDLE is ignored; dropping ce mid-REQ still installs.
        step(mk("t6.stray",  0, 32'h04, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 0, 32'h08, 16'd1));
        step(mk("t6.idle",   0, 32'h04, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h08, 16'd1));
        step(mk("t6.miss",   1, 32'h04, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h08, 16'd1));
        step(mk("t6.noce",   0, 32'h04, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h04, 16'd2));
        step(mk("t6.ack",    0, 32'h04, 1, 32'h1111_2222, 0, 0, 32'h0,         1, 1, 32'h04, 16'd2));
        step(mk("t6.hit",    1, 32'h04, 0, 32'h0,         0, 0, 32'h1111_2222, 0, 0, 32'h04, 16'd2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
